bcd_tick_counter: RTL and testbench

//   Multi-digit packed-BCD up/down counter advanced by the one-cycle tick from the clock divider.

---
 rtl/bcd_tick_counter.sv | 106 ++++++++++
 tb/tb_bcd_tick_counter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: packed-BCD up/down counter stepped by the divider tick.
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_tick        step enable (one step per high cycle)
//   i_up          direction, 1 = increment, 0 = decrement
//   i_clear       synchronous clear (highest priority)
//   i_load        synchronous load of i_load_value (rejected if any nibble > 9)
//   i_load_value  packed BCD load value, digit 0 in [3:0]
//   o_bcd         registered packed BCD count
//   o_carry       one-cycle pulse when a tick hits the upper/lower limit
//   o_load_err    one-cycle pulse when a load is rejected
//   o_zero        high while o_bcd is all zero
module bcd_tick_counter #(
    parameter int P_DIGITS = 4,
    parameter int P_WRAP   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_tick,
    input  logic                  i_up,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [4*P_DIGITS-1:0] i_load_value,
    output logic [4*P_DIGITS-1:0] o_bcd,
    output logic                  o_carry,
    output logic                  o_load_err,
    output logic                  o_zero
);

    localparam int W = 4 * P_DIGITS;

    logic [W-1:0] bcd_q;
    logic [W-1:0] bcd_d;
    logic [W-1:0] step_val;
    logic         carry_q;
    logic         carry_d;
    logic         err_q;
    logic         err_d;
    logic         load_ok;
    logic         chain;
    logic [3:0]   dig;

    // Ripple the step through the digits: a digit moves only while every
    // lower digit sits at its roll-over value. The chain surviving past the
    // top digit means the whole count was at the limit.
    always_comb begin
        step_val = bcd_q;
        chain    = 1'b1;
        load_ok  = 1'b1;
        dig      = '0;
        for (int k = 0; k < P_DIGITS; k++) begin
            dig = bcd_q[4*k +: 4];
            if (i_load_value[4*k +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
            if (chain) begin
                if (i_up) begin
                    step_val[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
                end else begin
                    step_val[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
                end
            end
            chain = chain & (i_up ? (dig == 4'd9) : (dig == 4'd0));
        end
    end

    // Priority clear > load > tick. At the limit the stepped value already
    // equals the wrapped value, so saturation simply keeps the old count.
    always_comb begin
        bcd_d   = bcd_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        if (i_clear) begin
            bcd_d = '0;
        end else if (i_load) begin
            if (load_ok) begin
                bcd_d = i_load_value;
            end else begin
                err_d = 1'b1;
            end
        end else if (i_tick) begin
            carry_d = chain;
            if (!chain || (P_WRAP != 0)) begin
                bcd_d = step_val;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bcd_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign o_bcd      = bcd_q;
    assign o_carry    = carry_q;
    assign o_load_err = err_q;
    assign o_zero     = (bcd_q == '0);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Testbench for bcd_tick_counter: wrapping and saturating instances driven
// together and compared against an integer-valued reference model.
module tb_bcd_tick_counter;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        up;
    logic        clr;
    logic        ld;
    logic [15:0] lv;
    logic [15:0] bcd_w, bcd_s;
    logic        carry_w, carry_s;
    logic        err_w, err_s;
    logic        zero_w, zero_s;

    int n_chk = 0;
    int n_err = 0;

    int m_val [2];
    bit m_carry [2];
    bit m_err;

    bcd_tick_counter #(.P_DIGITS(4), .P_WRAP(1)) u_wrap (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_up(up),
        .i_clear(clr), .i_load(ld), .i_load_value(lv),
        .o_bcd(bcd_w), .o_carry(carry_w), .o_load_err(err_w),
        .o_zero(zero_w)
    );

    bcd_tick_counter #(.P_DIGITS(4), .P_WRAP(0)) u_sat (
        .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_up(up),
        .i_clear(clr), .i_load(ld), .i_load_value(lv),
        .o_bcd(bcd_s), .o_carry(carry_s), .o_load_err(err_s),
        .o_zero(zero_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit is_bcd(input logic [15:0] x);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++)
            if (x[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int from_bcd(input logic [15:0] x);
        int v;
        v = 0;
        for (int k = 3; k >= 0; k--) v = v * 10 + int'(x[4*k +: 4]);
        return v;
    endfunction

    task automatic model_step(input bit c, input bit l,
                              input logic [15:0] val, input bit t,
                              input bit u);
        m_err = 1'b0;
        for (int w = 0; w < 2; w++) begin
            m_carry[w] = 1'b0;
            if (c) begin
                m_val[w] = 0;
            end else if (l) begin
                if (is_bcd(val)) m_val[w] = from_bcd(val);
                else m_err = 1'b1;
            end else if (t) begin
                if (u) begin
                    if (m_val[w] == 9999) begin
                        m_carry[w] = 1'b1;
                        if (w == 0) m_val[w] = 0;
                    end else begin
                        m_val[w] = m_val[w] + 1;
                    end
                end else begin
                    if (m_val[w] == 0) begin
                        m_carry[w] = 1'b1;
                        if (w == 0) m_val[w] = 9999;
                    end else begin
                        m_val[w] = m_val[w] - 1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("bcd_w", 32'(bcd_w), 32'(to_bcd(m_val[0])));
        chk("carry_w", 32'(carry_w), 32'(m_carry[0]));
        chk("err_w", 32'(err_w), 32'(m_err));
        chk("zero_w", 32'(zero_w), 32'(m_val[0] == 0));
        chk("bcd_s", 32'(bcd_s), 32'(to_bcd(m_val[1])));
        chk("carry_s", 32'(carry_s), 32'(m_carry[1]));
        chk("err_s", 32'(err_s), 32'(m_err));
        chk("zero_s", 32'(zero_s), 32'(m_val[1] == 0));
        chk("nib_w", 32'(is_bcd(bcd_w)), 32'd1);
        chk("nib_s", 32'(is_bcd(bcd_s)), 32'd1);
    endtask

    task automatic cyc(input bit c, input bit l, input logic [15:0] val,
                       input bit t, input bit u);
        clr  = c;
        ld   = l;
        lv   = val;
        tick = t;
        up   = u;
        @(posedge clk);
        model_step(c, l, val, t, u);
        #1;
        compare();
    endtask

    initial begin
        int r;
        logic [15:0] v;
        rst_n = 1'b0;
        tick = 1'b0;
        up = 1'b1;
        clr = 1'b0;
        ld = 1'b0;
        lv = '0;
        m_val[0] = 0;
        m_val[1] = 0;
        m_carry[0] = 1'b0;
        m_carry[1] = 1'b0;
        m_err = 1'b0;
        #2;
        chk("rst_bcd", 32'(bcd_w), 32'h0);
        chk("rst_carry", 32'(carry_w), 32'h0);
        chk("rst_err", 32'(err_w), 32'h0);
        chk("rst_zero", 32'(zero_w), 32'h1);
        #10;
        rst_n = 1'b1;

        // ten single up ticks
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 16'h0, 1, 1);
            cyc(0, 0, 16'h0, 0, 1);
        end
        chk("ten_ticks", 32'(bcd_w), 32'h0010);

        // upper limit
        cyc(0, 1, 16'h9998, 0, 1);
        cyc(0, 0, 16'h0, 1, 1);
        chk("up_9999", 32'(bcd_w), 32'h9999);
        cyc(0, 0, 16'h0, 1, 1);
        chk("up_wrap", 32'(bcd_w), 32'h0000);
        chk("up_sat", 32'(bcd_s), 32'h9999);
        chk("up_carry", 32'(carry_w), 32'h1);
        cyc(0, 0, 16'h0, 0, 1);
        chk("carry_one", 32'(carry_w), 32'h0);

        // borrow ripple and lower limit
        cyc(0, 1, 16'h1000, 0, 0);
        cyc(0, 0, 16'h0, 1, 0);
        chk("dn_0999", 32'(bcd_w), 32'h0999);
        cyc(1, 0, 16'h0, 0, 0);
        cyc(0, 0, 16'h0, 1, 0);
        chk("dn_wrap", 32'(bcd_w), 32'h9999);
        chk("dn_sat", 32'(bcd_s), 32'h0000);

        // rejected load, also blocks a same-cycle tick
        cyc(0, 1, 16'h0123, 0, 1);
        cyc(0, 1, 16'h12A4, 1, 1);
        chk("bad_load", 32'(bcd_w), 32'h0123);
        chk("bad_err", 32'(err_w), 32'h1);
        cyc(0, 0, 16'h0, 0, 1);

        // priority clear > load > tick
        cyc(0, 1, 16'h0555, 0, 1);
        cyc(1, 1, 16'h0042, 1, 1);
        chk("clr_pri", 32'(bcd_w), 32'h0);
        cyc(0, 1, 16'h0042, 1, 1);
        chk("ld_pri", 32'(bcd_w), 32'h0042);

        // held tick, then asynchronous reset mid-run
        cyc(1, 0, 16'h0, 0, 1);
        for (int i = 0; i < 12; i++) cyc(0, 0, 16'h0, 1, 1);
        chk("held12", 32'(bcd_w), 32'h0012);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_bcd", 32'(bcd_w), 32'h0);
        chk("async_zero", 32'(zero_w), 32'h1);
        chk("async_sat", 32'(bcd_s), 32'h0);
        m_val[0] = 0;
        m_val[1] = 0;
        m_carry[0] = 1'b0;
        m_carry[1] = 1'b0;
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 0, 16'h0, 1, 1);
        chk("post_rst", 32'(bcd_w), 32'h0001);

        // random traffic, loads biased toward the limits
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 3))
                0: v = 16'($urandom);
                1: v = to_bcd(int'($urandom_range(9990, 9999)));
                2: v = to_bcd(int'($urandom_range(0, 9)));
                default: v = to_bcd(int'($urandom_range(0, 9999)));
            endcase
            cyc(r < 4, r < 14, v, $urandom_range(0, 9) < 7,
                $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
